fixed_point_argbest: RTL and testbench

Streaming signed fixed-point arg-min/arg-max tracker. It consumes a frame of values over a valid/ready stream and keeps a running best value and its index using a signed three-way compare. When the frame ends it presents the best value, its index and the frame length through an output handshake. It sits downstream of the fitness evaluators and selects the leading candidate of each population sweep.

---
 rtl/fixed_point_pkg.sv | 17 +
 rtl/fixed_point_select.sv | 26 ++
 rtl/fixed_point_argbest.sv | 117 +++++++++++
 tb/tb_fixed_point_argbest.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared states, mode encodings and sizing helper for the arg-best tracker
package fixed_point_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fixed_point_select.sv
// fixed_point_select: decides whether a candidate displaces the running best
module fixed_point_select
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] cand,
    input  logic signed [WIDTH-1:0] best,
    input  logic                    mode,
    input  logic                    tie_latest,
    output logic                    replace
);

    logic gt;
    logic eq;
    logic lt;

    // signed three-way compare; equality defers to the tie policy
    always_comb begin
        gt = cand > best;
        eq = cand == best;
        lt = cand < best;
        replace = eq ? tie_latest : (mode == MODE_MAX) ? gt : lt;
    end

endmodule

// File: rtl/fixed_point_argbest.sv
// fixed_point_argbest: streaming signed arg-min/arg-max over a framed valid/ready stream
module fixed_point_argbest
    import fixed_point_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_ITEMS  = 16,
    parameter int TIE_LATEST = 0,
    localparam int IDXW      = idx_width(MAX_ITEMS)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    mode_in,
    input  logic signed [WIDTH-1:0] value_in,
    input  logic                    valid_in,
    input  logic                    last_in,
    output logic                    ready_out,
    output logic signed [WIDTH-1:0] best_value_out,
    output logic [IDXW-1:0]         best_index_out,
    output logic [IDXW:0]           count_out,
    output logic                    overflow_out,
    output logic                    valid_out,
    input  logic                    ready_in
);

    localparam logic [IDXW:0] LAST_POS = (IDXW + 1)'(MAX_ITEMS - 1);

    state_t                  state;
    state_t                  state_nx;
    logic                    mode_r;
    logic signed [WIDTH-1:0] best;
    logic [IDXW-1:0]         idx;
    logic [IDXW:0]           count;
    logic                    accept;
    logic                    first;
    logic                    replace;
    logic                    truncate;
    logic                    frame_end;
    logic signed [WIDTH-1:0] best_nx;
    logic [IDXW-1:0]         idx_nx;
    logic [IDXW:0]           count_nx;

    fixed_point_select #(
        .WIDTH(WIDTH)
    ) u_select (
        .cand      (value_in),
        .best      (best),
        .mode      (mode_r),
        .tie_latest(TIE_LATEST != 0),
        .replace   (replace)
    );

    // beat qualification and the running-best candidate values for this beat
    always_comb begin
        accept    = valid_in & ready_out;
        first     = state == IDLE;
        truncate  = state == SCAN && count == LAST_POS && !last_in;
        frame_end = accept & (last_in | truncate);
        best_nx   = (first | replace) ? value_in : best;
        idx_nx    = first ? '0 : replace ? count[IDXW-1:0] : idx;
        count_nx  = first ? (IDXW + 1)'(1) : count + 1'b1;
    end

    // next-state: IDLE opens a frame, SCAN runs until last/truncation, DONE waits for the sink
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (last_in ? DONE : SCAN) : IDLE;
            SCAN:    state_nx = frame_end ? DONE : SCAN;
            DONE:    state_nx = ready_in ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // state register plus registered handshake flags derived from the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ready_out <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nx;
            ready_out <= state_nx != DONE;
            valid_out <= state_nx == DONE;
        end
    end

    // running best/index/count advance only on accepted beats; mode latched at frame start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_r <= MODE_MIN;
            best   <= '0;
            idx    <= '0;
            count  <= '0;
        end else if (accept) begin
            mode_r <= first ? mode_in : mode_r;
            best   <= best_nx;
            idx    <= idx_nx;
            count  <= count_nx;
        end
    end

    // result registers capture the final beat's outcome and hold until the next frame ends
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            best_value_out <= '0;
            best_index_out <= '0;
            count_out      <= '0;
            overflow_out   <= 1'b0;
        end else if (frame_end) begin
            best_value_out <= best_nx;
            best_index_out <= idx_nx;
            count_out      <= count_nx;
            overflow_out   <= truncate;
        end
    end

endmodule

// File: tb/tb_fixed_point_argbest.sv
// tb_fixed_point_argbest: directed-vector self-checking bench for fixed_point_argbest
module tb_fixed_point_argbest;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic md = 1'b0;
    logic vi = 1'b0;
    logic li = 1'b0;
    logic ri = 1'b0;
    logic g = 1'b0;
    logic signed [7:0] val = '0;

    logic r0, v0, o0, r1, v1, o1, r2, v2, o2;
    logic signed [7:0] b0, b1, b2;
    logic [3:0] i0, i1;
    logic [4:0] c0, c1;
    logic [1:0] i2;
    logic [2:0] c2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fixed_point_argbest #(.WIDTH(8), .MAX_ITEMS(16), .TIE_LATEST(0)) dut0 (
        .clk(clk), .rstn(rstn), .mode_in(md), .value_in(val), .valid_in(vi & ~g),
        .last_in(li), .ready_out(r0), .best_value_out(b0), .best_index_out(i0),
        .count_out(c0), .overflow_out(o0), .valid_out(v0), .ready_in(ri & ~g)
    );

    fixed_point_argbest #(.WIDTH(8), .MAX_ITEMS(16), .TIE_LATEST(1)) dut1 (
        .clk(clk), .rstn(rstn), .mode_in(md), .value_in(val), .valid_in(vi & ~g),
        .last_in(li), .ready_out(r1), .best_value_out(b1), .best_index_out(i1),
        .count_out(c1), .overflow_out(o1), .valid_out(v1), .ready_in(ri & ~g)
    );

    fixed_point_argbest #(.WIDTH(8), .MAX_ITEMS(4), .TIE_LATEST(0)) dut2 (
        .clk(clk), .rstn(rstn), .mode_in(md), .value_in(val), .valid_in(vi & g),
        .last_in(li), .ready_out(r2), .best_value_out(b2), .best_index_out(i2),
        .count_out(c2), .overflow_out(o2), .valid_out(v2), .ready_in(ri & g)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic beat(input int v, input logic l);
        @(negedge clk);
        val = 8'(v);
        vi = 1'b1;
        li = l;
    endtask

    task automatic idle_in();
        @(negedge clk);
        vi = 1'b0;
        li = 1'b0;
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        ri = 1'b1;
        @(negedge clk);
        ri = 1'b0;
        chk({tag, "_vld0"}, g ? int'(v2) : int'(v0), 0);
        chk({tag, "_rdy1"}, g ? int'(r2) : int'(r0), 1);
    endtask

    task automatic zeros(input string tag);
        chk({tag, "_z"}, int'({r0, v0, o0, b0, i0, c0}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        #12;
        zeros("reset");
        @(negedge clk);
        rstn = 1'b1;
        chk("rdy_before_edge", int'(r0), 0);
        @(negedge clk);
        chk("rdy_after_edge", int'(r0), 1);

        // min, ties: earliest on dut0, latest on dut1
        md = 1'b0;
        beat(3, 0); beat(-5, 0); beat(7, 0);
        beat(-5, 1);
        chk("a_vld_early", int'(v0), 0);
        idle_in();
        chk("a_vld", int'(v0), 1);
        chk("a_rdy", int'(r0), 0);
        chk("a_best", int'(b0), -5);
        chk("a_idx", int'(i0), 1);
        chk("a_cnt", int'(c0), 4);
        chk("a_ovf", int'(o0), 0);
        chk("a_tie_best", int'(b1), -5);
        chk("a_tie_idx", int'(i1), 3);
        handshake("a");

        // max, with mode toggled mid-frame
        md = 1'b1;
        beat(3, 0); beat(-5, 0);
        md = 1'b0;
        beat(7, 0);
        md = 1'b1;
        beat(-5, 1);
        idle_in();
        chk("b_best", int'(b0), 7);
        chk("b_idx", int'(i0), 2);
        chk("b_cnt", int'(c0), 4);
        handshake("b");

        // extremes in min mode
        md = 1'b0;
        beat(127, 0); beat(-128, 1);
        idle_in();
        chk("c_best", int'(b0), -128);
        chk("c_idx", int'(i0), 1);
        chk("c_cnt", int'(c0), 2);
        handshake("c");

        // single-beat frame
        beat(-1, 1);
        idle_in();
        chk("d_vld", int'(v0), 1);
        chk("d_best", int'(b0), -1);
        chk("d_idx", int'(i0), 0);
        chk("d_cnt", int'(c0), 1);
        handshake("d");

        // truncation at MAX_ITEMS=4; the fifth beat opens a new frame
        g = 1'b1;
        beat(1, 0); beat(2, 0); beat(3, 0); beat(4, 0);
        idle_in();
        chk("e_vld", int'(v2), 1);
        chk("e_rdy", int'(r2), 0);
        chk("e_best", int'(b2), 1);
        chk("e_idx", int'(i2), 0);
        chk("e_cnt", int'(c2), 4);
        chk("e_ovf", int'(o2), 1);
        handshake("e");
        beat(9, 1);
        idle_in();
        chk("f_best", int'(b2), 9);
        chk("f_cnt", int'(c2), 1);
        chk("f_ovf", int'(o2), 0);
        handshake("f");
        g = 1'b0;

        // back-pressure: result holds, stray beats refused
        beat(5, 0); beat(6, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            val = 8'(100 + k);
            vi = k[0];
            li = 1'b1;
            chk("g_hold", int'({v0, r0, b0, i0, c0}), int'({1'b1, 1'b0, 8'sd5, 4'd0, 5'd2}));
        end
        idle_in();
        handshake("g");
        beat(2, 1);
        idle_in();
        chk("h_best", int'(b0), 2);
        chk("h_cnt", int'(c0), 1);
        handshake("h");

        // reset mid-scan
        beat(10, 0); beat(-20, 0);
        @(negedge clk);
        vi = 1'b0;
        rstn = 1'b0;
        #1;
        zeros("rst_scan");
        @(negedge clk);
        rstn = 1'b1;
        beat(4, 0); beat(8, 0); beat(-3, 1);
        idle_in();
        chk("i_best", int'(b0), -3);
        chk("i_idx", int'(i0), 2);
        chk("i_cnt", int'(c0), 3);

        // reset while the result is pending
        #2;
        rstn = 1'b0;
        #1;
        zeros("rst_done");
        @(negedge clk);
        rstn = 1'b1;
        beat(6, 1);
        idle_in();
        chk("j_best", int'(b0), 6);
        chk("j_idx", int'(i0), 0);
        chk("j_cnt", int'(c0), 1);
        handshake("j");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
